// File: rtl/fetch_queue.sv
// fetch_queue: RV32I fetch stage with a single outstanding imem read
// and a small PC/instruction queue presented to decode.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(QDEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   drain_addr_q, drain_addr_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_mem_q [QDEPTH];
  logic [31:0]   pc_mem_d [QDEPTH];
  logic [31:0]   ins_mem_q [QDEPTH];
  logic [31:0]   ins_mem_d [QDEPTH];

  logic          pop;
  logic          push;
  logic [CW-1:0] count_pop;
  logic [CW-1:0] count_push;
  logic [31:0]   new_pc;

  always_comb begin
    id_valid       = (count_q != '0) && !redirect;
    pop            = id_valid && id_ready;
    count_pop      = count_q - CW'(pop);
    count_push     = count_pop + CW'(1);
    new_pc         = redirect_pc & ~32'h3;
    id_instruction = id_valid ? ins_mem_q[head_q] : NOP;
    id_pc          = id_valid ? pc_mem_q[head_q] : '0;
    imem_read      = (state_q != IDLE);
    imem_address   = (state_q == DRAIN) ? drain_addr_q
                                        : fetch_pc_q;
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;
    push         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (redirect || (count_pop < DEPTH)) state_d = REQ;
      end
      REQ: begin
        if (redirect) begin
          // a response arriving with the redirect is simply dropped
          state_d      = imem_resp ? REQ : DRAIN;
          drain_addr_d = fetch_pc_q;
        end else if (imem_resp) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = (count_push < DEPTH) ? REQ : IDLE;
        end
      end
      DRAIN: begin
        if (imem_resp) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
    if (redirect) fetch_pc_d = new_pc;
  end

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    pc_mem_d  = pc_mem_q;
    ins_mem_d = ins_mem_q;
    if (redirect) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        pc_mem_d[tail_q]  = fetch_pc_q;
        ins_mem_d[tail_q] = imem_rdata;
        tail_d            = tail_q + PW'(1);
      end
      if (pop) head_d = head_q + PW'(1);
      count_d = push ? count_push : count_pop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      drain_addr_q <= RESET_PC;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        pc_mem_q[i]  <= '0;
        ins_mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      pc_mem_q     <= pc_mem_d;
      ins_mem_q    <= ins_mem_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a latency-programmable memory
// and a queue-level reference model checked every cycle.
module tb_fetch_queue;

  localparam int QD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_resp = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;

  int vectors = 0;
  int miscompares = 0;
  int lat = 1;
  int mem_cnt = 0;

  logic [31:0] mq[$];
  logic [31:0] m_fpc = 32'h60;
  logic [31:0] m_addr = 32'h60;
  bit          m_busy = 1'b0;
  bit          m_drain = 1'b0;

  fetch_queue dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_read(imem_read),
    .imem_address(imem_address),
    .imem_resp(imem_resp),
    .imem_rdata(imem_rdata),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .id_ready(id_ready),
    .id_valid(id_valid),
    .id_instruction(id_instruction),
    .id_pc(id_pc)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // memory: answers on the lat-th cycle a request has been presented
  task automatic step();
    @(posedge clk);
    #1;
    redirect = 1'b0;
    if (!rst_n || !imem_read) begin
      mem_cnt   = 0;
      imem_resp = 1'b0;
    end else begin
      imem_resp = (mem_cnt == lat - 1);
      mem_cnt   = imem_resp ? 0 : mem_cnt + 1;
    end
    imem_rdata = imem_resp ? memfn(imem_address) : 32'hDEAD_BEEF;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin : cmp
    logic        e_read, e_val, pop;
    logic [31:0] e_addr, e_pc, e_ins;
    if (!rst_n) begin
      mq.delete();
      m_fpc   = 32'h60;
      m_addr  = 32'h60;
      m_busy  = 1'b0;
      m_drain = 1'b0;
    end
    e_read = m_busy;
    e_addr = m_busy ? m_addr : m_fpc;
    e_val  = (mq.size() != 0) && !redirect;
    e_pc   = e_val ? mq[0] : 32'h0;
    e_ins  = e_val ? memfn(mq[0]) : 32'h13;
    chk("m_read", {31'h0, imem_read}, {31'h0, e_read});
    chk("m_addr", imem_address, e_addr);
    chk("m_valid", {31'h0, id_valid}, {31'h0, e_val});
    chk("m_pc", id_pc, e_pc);
    chk("m_ins", id_instruction, e_ins);
    if (rst_n) begin
      pop = e_val && id_ready;
      if (redirect) begin
        mq.delete();
        m_fpc = redirect_pc & ~32'h3;
        if (m_busy && !imem_resp) begin
          m_drain = 1'b1;
        end else begin
          m_busy  = 1'b1;
          m_drain = 1'b0;
          m_addr  = m_fpc;
        end
      end else begin
        if (pop) void'(mq.pop_front());
        if (m_busy && imem_resp) begin
          if (m_drain) begin
            m_drain = 1'b0;
            m_addr  = m_fpc;
          end else begin
            mq.push_back(m_addr);
            m_fpc = m_fpc + 32'd4;
            if (mq.size() < QD) m_addr = m_fpc;
            else m_busy = 1'b0;
          end
        end else if (!m_busy && mq.size() < QD) begin
          m_busy = 1'b1;
          m_addr = m_fpc;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    // 1: single-cycle memory streams one word per cycle
    lat = 1;
    id_ready = 1'b1;
    do_reset();
    chk("t1_rst_read", {31'h0, imem_read}, 32'h0);
    chk("t1_rst_addr", imem_address, 32'h60);
    chk("t1_rst_ins", id_instruction, 32'h13);
    step();
    chk("t1_a0", imem_address, 32'h60);
    chk("t1_v0", {31'h0, id_valid}, 32'h0);
    step();
    chk("t1_a1", imem_address, 32'h64);
    chk("t1_pc0", id_pc, 32'h60);
    step();
    chk("t1_a2", imem_address, 32'h68);
    chk("t1_pc1", id_pc, 32'h64);

    // 2: decode stalled, queue fills and fetch idles
    lat = 3;
    id_ready = 1'b0;
    do_reset();
    steps(7);
    chk("t2_idle", {31'h0, imem_read}, 32'h0);
    chk("t2_head", id_pc, 32'h60);
    steps(2);
    chk("t2_hold", id_pc, 32'h60);
    chk("t2_hold_ins", id_instruction, 32'hC0DE_0060);
    id_ready = 1'b1;
    step();
    chk("t2_pc1", id_pc, 32'h64);
    chk("t2_resume", imem_address, 32'h68);

    // 3: redirect while a request is pending goes through DRAIN
    lat = 3;
    do_reset();
    steps(4);
    chk("t3_pend", imem_address, 32'h64);
    redirect = 1'b1;
    redirect_pc = 32'h200;
    #1;
    chk("t3_kill", {31'h0, id_valid}, 32'h0);
    step();
    chk("t3_hold", imem_address, 32'h64);
    step();
    chk("t3_hold2", imem_address, 32'h64);
    step();
    chk("t3_new", imem_address, 32'h200);
    chk("t3_empty", {31'h0, id_valid}, 32'h0);
    steps(3);
    chk("t3_pc", id_pc, 32'h200);
    chk("t3_ins", id_instruction, 32'hC0DE_0200);

    // 4: redirect coincident with a response
    lat = 2;
    do_reset();
    steps(2);
    redirect = 1'b1;
    redirect_pc = 32'h104;
    step();
    chk("t4_addr", imem_address, 32'h104);
    chk("t4_nostale", {31'h0, id_valid}, 32'h0);
    steps(2);
    chk("t4_pc", id_pc, 32'h104);

    // 5: low bits of redirect_pc dropped, PC wraps past the top
    lat = 1;
    do_reset();
    redirect = 1'b1;
    redirect_pc = 32'h203;
    step();
    chk("t5_align", imem_address, 32'h200);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    chk("t5_top", imem_address, 32'hFFFF_FFFC);
    step();
    chk("t5_wrap", imem_address, 32'h0);
    chk("t5_pc", id_pc, 32'hFFFF_FFFC);

    // 6: asynchronous reset while draining
    lat = 4;
    do_reset();
    redirect = 1'b1;
    redirect_pc = 32'h300;
    step();
    redirect = 1'b1;
    redirect_pc = 32'h500;
    step();
    chk("t6_drain", imem_address, 32'h300);
    rst_n = 1'b0;
    #1;
    chk("t6_read", {31'h0, imem_read}, 32'h0);
    chk("t6_addr", imem_address, 32'h60);
    chk("t6_pc", id_pc, 32'h0);
    chk("t6_ins", id_instruction, 32'h13);
    steps(2);
    rst_n = 1'b1;
    step();
    chk("t6_first", imem_address, 32'h60);
    chk("t6_req", {31'h0, imem_read}, 32'h1);

    // mixed traffic: intermittent stalls and redirects
    lat = 2;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      id_ready = (i % 3) != 0;
      if (i == 17) begin
        redirect = 1'b1;
        redirect_pc = 32'h4000;
      end
      if (i == 30) begin
        redirect = 1'b1;
        redirect_pc = 32'h5002;
      end
      step();
    end
    steps(2);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
